// File: rtl/cache_pkg.sv
// Shared widths, address layout and controller state encoding for the
// direct-mapped byte-read cache.
package cache_pkg;

  localparam int CACHE_SIZE = 1024;
  localparam int WORD_NUM   = 32;
  localparam int DATA_WID   = 64;

  localparam int IDX_W = $clog2(CACHE_SIZE);
  localparam int WRD_W = $clog2(WORD_NUM);
  localparam int BYT_W = $clog2(DATA_WID / 8);
  localparam int TAG_W = 32 - IDX_W - WRD_W - BYT_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [WRD_W-1:0] wrd;
    logic [BYT_W-1:0] byt;
  } cache_addr_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    HIT_DATA = 3'd2,
    MEM_REQ  = 3'd3,
    REFILL   = 3'd4
  } cache_state_e;

endpackage

// File: rtl/cache_tag_ram.sv
// Tag storage: one registered read port and one write port. Contents are not
// reset; the valid vector in the controller qualifies every entry.
module cache_tag_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 14
) (
  input  logic          clk_i,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] rd_data_r;

  // Array write and one-cycle registered read.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Lookup and burst-refill sequencer for the direct-mapped byte-read cache:
// owns tag/valid state, serves hits from the data store and refills on misses.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int cache_size = CACHE_SIZE,
  parameter int word_num   = WORD_NUM,
  parameter int data_wid   = DATA_WID
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_i,
  input  logic [31:0]                   addr_i,
  input  logic                          flush_i,
  output logic                          ready_o,
  output logic                          rvalid_o,
  output logic [7:0]                    rdata_o,
  output logic                          hit_o,
  output logic                          mem_req_o,
  output logic [31:0]                   mem_addr_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [data_wid-1:0]           mem_rdata_i,
  output logic                          ds_re_o,
  output logic                          ds_we_o,
  output logic [$clog2(cache_size)-1:0] ds_idx_o,
  output logic [$clog2(word_num)-1:0]   ds_wrd_o,
  output logic [$clog2(data_wid/8)-1:0] ds_byt_o,
  output logic [data_wid-1:0]           ds_wdata_o,
  input  logic [7:0]                    ds_rdata_i
);

  // Local widths follow the instance parameters rather than the package defaults.
  localparam int IW = $clog2(cache_size);
  localparam int WW = $clog2(word_num);
  localparam int BW = $clog2(data_wid / 8);
  localparam int TW = 32 - IW - WW - BW;
  localparam logic [WW-1:0] LAST_WRD = WW'(word_num - 1);

  cache_state_e         state_r;
  logic [TW-1:0]        tag_r;
  logic [IW-1:0]        idx_r;
  logic [WW-1:0]        wrd_r;
  logic [BW-1:0]        byt_r;
  logic [WW-1:0]        beat_cnt_r;
  logic [cache_size-1:0] valid_r;
  logic [7:0]           cap_byte_r;
  logic                 rvalid_r;
  logic                 hit_r;
  logic [7:0]           rdata_r;

  logic                 accept_s;
  logic                 hit_s;
  logic                 last_beat_s;
  logic                 tag_we_s;
  logic [TW-1:0]        tag_rd_s;
  logic [7:0]           beat_byte_s;
  logic [BW+2:0]        byte_sel_s;

  assign ready_o     = rst_ni && (state_r == IDLE);
  assign accept_s    = ready_o && req_i && !flush_i;
  assign hit_s       = valid_r[idx_r] && (tag_rd_s == tag_r);
  assign last_beat_s = (beat_cnt_r == LAST_WRD);
  assign tag_we_s    = rst_ni && (state_r == REFILL) && mem_rvalid_i && last_beat_s;

  // Requested byte lane of the beat currently on the memory bus.
  always_comb begin
    byte_sel_s  = {byt_r, 3'b000};
    beat_byte_s = mem_rdata_i[byte_sel_s +: 8];
  end

  cache_tag_ram #(
    .DEPTH (cache_size),
    .AW    (IW),
    .DW    (TW)
  ) u_tag_ram (
    .clk_i   (clk_i),
    .rd_en   (accept_s),
    .rd_addr (addr_i[WW+BW +: IW]),
    .rd_data (tag_rd_s),
    .wr_en   (tag_we_s),
    .wr_addr (idx_r),
    .wr_data (tag_r)
  );

  // Controller FSM with valid vector, beat counter and registered response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      valid_r    <= '0;
      beat_cnt_r <= '0;
      tag_r      <= '0;
      idx_r      <= '0;
      wrd_r      <= '0;
      byt_r      <= '0;
      cap_byte_r <= 8'h00;
      rvalid_r   <= 1'b0;
      hit_r      <= 1'b0;
      rdata_r    <= 8'h00;
    end else begin
      rvalid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (flush_i) begin
            valid_r <= '0;
          end else if (req_i) begin
            tag_r   <= addr_i[31 -: TW];
            idx_r   <= addr_i[WW+BW +: IW];
            wrd_r   <= addr_i[BW +: WW];
            byt_r   <= addr_i[0 +: BW];
            state_r <= LOOKUP;
          end
        end
        LOOKUP: begin
          state_r <= hit_s ? HIT_DATA : MEM_REQ;
        end
        HIT_DATA: begin
          rdata_r  <= ds_rdata_i;
          rvalid_r <= 1'b1;
          hit_r    <= 1'b1;
          state_r  <= IDLE;
        end
        MEM_REQ: begin
          // Line is invalid from grant until its last beat lands.
          if (mem_gnt_i) begin
            valid_r[idx_r] <= 1'b0;
            beat_cnt_r     <= '0;
            state_r        <= REFILL;
          end
        end
        REFILL: begin
          if (mem_rvalid_i) begin
            beat_cnt_r <= beat_cnt_r + WW'(1);
            if (beat_cnt_r == wrd_r) begin
              cap_byte_r <= beat_byte_s;
            end
            if (last_beat_s) begin
              valid_r[idx_r] <= 1'b1;
              rvalid_r       <= 1'b1;
              hit_r          <= 1'b0;
              rdata_r        <= (beat_cnt_r == wrd_r) ? beat_byte_s : cap_byte_r;
              state_r        <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Data-store and memory-bus strobes are forced low while reset is asserted.
  always_comb begin
    ds_re_o   = 1'b0;
    ds_we_o   = 1'b0;
    mem_req_o = 1'b0;
    ds_wrd_o  = wrd_r;
    if (rst_ni) begin
      ds_re_o   = (state_r == LOOKUP) && hit_s;
      ds_we_o   = (state_r == REFILL) && mem_rvalid_i;
      mem_req_o = (state_r == MEM_REQ);
    end else begin
      ds_re_o   = 1'b0;
      ds_we_o   = 1'b0;
      mem_req_o = 1'b0;
    end
    if (state_r == REFILL) begin
      ds_wrd_o = beat_cnt_r;
    end else begin
      ds_wrd_o = wrd_r;
    end
  end

  assign ds_idx_o   = idx_r;
  assign ds_byt_o   = byt_r;
  assign ds_wdata_o = mem_rdata_i;
  assign mem_addr_o = {tag_r, idx_r, {(WW + BW){1'b0}}};
  assign rvalid_o   = rvalid_r;
  assign hit_o      = hit_r;
  assign rdata_o    = rdata_r;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed scoreboard bench for cache_refill_ctrl: stimulus pushes expected
// responses, a negedge monitor pops and compares them against rvalid_o.
module tb_cache_refill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        flush;
  logic        ready;
  logic        rvalid;
  logic [7:0]  rdata;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        ds_re;
  logic        ds_we;
  logic [9:0]  ds_idx;
  logic [4:0]  ds_wrd;
  logic [2:0]  ds_byt;
  logic [63:0] ds_wdata;
  logic [7:0]  ds_rdata;

  cache_refill_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .addr_i       (addr),
    .flush_i      (flush),
    .ready_o      (ready),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .hit_o        (hit),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .ds_re_o      (ds_re),
    .ds_we_o      (ds_we),
    .ds_idx_o     (ds_idx),
    .ds_wrd_o     (ds_wrd),
    .ds_byt_o     (ds_byt),
    .ds_wdata_o   (ds_wdata),
    .ds_rdata_i   (ds_rdata)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int rv_cyc = 0;
  int we_cnt = 0;
  int memreq_cnt = 0;
  int overlap_cnt = 0;
  logic [8:0]  sb_q [$];
  logic [63:0] ds_mem [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] beat_data(input logic [7:0] base, input int k);
    logic [7:0] b;
    b = base + k[7:0];
    return {8{b}};
  endfunction

  function automatic logic [7:0] ds_read(input int key, input int b);
    logic [63:0] w;
    w = ds_mem.exists(key) ? ds_mem[key] : 64'h0;
    return w[b*8 +: 8];
  endfunction

  // Data-store model: registered byte read one cycle after ds_re.
  always @(posedge clk) begin
    if (ds_re) ds_rdata <= ds_read(int'({ds_idx, ds_wrd}), int'(ds_byt));
  end

  // Monitor: data-store writes, strobe bookkeeping and scoreboard pops.
  always @(negedge clk) begin
    if (ds_we) begin
      we_cnt++;
      ds_mem[int'({ds_idx, ds_wrd})] = ds_wdata;
    end
    if (ds_we && ds_re) overlap_cnt++;
    if (mem_req) memreq_cnt++;
    if (rvalid) begin
      rv_cyc = cyc;
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rvalid: rvalid_o=1 rdata_o=%0h with no response outstanding", rdata);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("resp_hit", {63'd0, hit}, {63'd0, e[8]});
        chk("resp_data", {56'd0, rdata}, {56'd0, e[7:0]});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", {63'd0, ready}, 64'd1);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("resp_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  // One CPU read plus the memory side of its refill (if a miss is expected).
  task automatic do_read(input logic [31:0] a, input bit exp_hit, input logic [7:0] exp_data,
                         input logic [7:0] base, input int gnt_dly, input int gap_beat,
                         input int abort_beat);
    int acc_cyc, m0, w0, n;
    logic [31:0] exp_maddr;
    exp_maddr = a & 32'hFFFF_FF00;
    wait_ready();
    if (abort_beat < 0) sb_q.push_back({exp_hit, exp_data});
    m0 = memreq_cnt;
    req = 1'b1;
    addr = a;
    acc_cyc = cyc;
    @(posedge clk); #1;
    req = 1'b0;
    if (exp_hit) begin
      wait_resp();
      chk("hit_latency", 64'(rv_cyc - acc_cyc), 64'd3);
      chk("hit_no_memreq", 64'(memreq_cnt - m0), 64'd0);
    end else begin
      n = 0;
      while (!mem_req && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("memreq_seen", {63'd0, mem_req}, 64'd1);
      chk("mem_addr", {32'd0, mem_addr}, {32'd0, exp_maddr});
      for (int d = 0; d < gnt_dly; d++) begin
        @(posedge clk); #1;
        chk("memreq_held", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, exp_maddr});
      end
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      w0 = we_cnt;
      for (int k = 0; k < 32; k++) begin
        if (k == gap_beat) begin
          mem_rvalid = 1'b0;
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b1;
        mem_rdata = beat_data(base, k);
        if (k == abort_beat) begin
          rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          mem_rvalid = 1'b0;
          chk("abort_we_pulses", 64'(we_cnt - w0), 64'(abort_beat));
          w0 = we_cnt;
          for (int s = 0; s < 5; s++) begin
            mem_rvalid = 1'b1;
            mem_rdata = beat_data(base, k + 1 + s);
            @(posedge clk); #1;
          end
          mem_rvalid = 1'b0;
          @(posedge clk); #1;
          chk("stray_we_pulses", 64'(we_cnt - w0), 64'd0);
          return;
        end
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
      chk("we_pulses", 64'(we_cnt - w0), 64'd32);
      wait_resp();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0;
    addr = 32'h0;
    flush = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 64'h0;
    ds_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_rdata", {56'd0, rdata}, 64'd0);
    chk("rst_memreq", {63'd0, mem_req}, 64'd0);
    chk("rst_ds_we_re", {62'd0, ds_we, ds_re}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {63'd0, ready}, 64'd1);

    // 1: cold miss; 2: hit; 3: conflict misses on idx 0x12
    do_read(32'h0000_1234, 1'b0, 8'h06, 8'h00, 0, -1, -1);
    do_read(32'h0000_1234, 1'b1, 8'h06, 8'h00, 0, -1, -1);
    do_read(32'h0004_1234, 1'b0, 8'hA6, 8'hA0, 0, -1, -1);
    do_read(32'h0000_1234, 1'b0, 8'h06, 8'h00, 0, -1, -1);

    // 4: flush with a simultaneous request; the request must not be taken
    wait_ready();
    flush = 1'b1;
    req = 1'b1;
    addr = 32'h0000_1234;
    @(posedge clk); #1;
    flush = 1'b0;
    req = 1'b0;
    chk("flush_no_accept", {63'd0, ready}, 64'd1);
    do_read(32'h0000_1234, 1'b0, 8'h06, 8'h00, 0, -1, -1);

    // 5: grant delayed 5 cycles, one-cycle gap before beat 3
    do_read(32'h0000_2345, 1'b0, 8'h08, 8'h00, 5, 3, -1);
    do_read(32'h0000_2345, 1'b1, 8'h08, 8'h00, 0, -1, -1);

    // 6: reset during beat 10, stray beats, then the same address misses
    do_read(32'h0000_3456, 1'b0, 8'h0A, 8'h00, 0, -1, 10);
    do_read(32'h0000_3456, 1'b0, 8'h0A, 8'h00, 0, -1, -1);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    chk("ds_re_we_overlap", 64'(overlap_cnt), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
